// File: rtl/sub_mult_abs_vec.sv
// Multi-lane pipelined |(x - grid) * scale| stage for the KAN datapath.
// Joins data/grid/scale AXI-Stream inputs; 3-stage pipe with round and saturate.
module sub_mult_abs_vec #(
  parameter int LANES                 = 4,
  parameter int DATA_WIDTH_DATA       = 16,
  parameter int FRACTIONAL_BITS_DATA  = 12,
  parameter int DATA_WIDTH_SCALE      = 16,
  parameter int FRACTIONAL_BITS_SCALE = 12,
  parameter int DATA_WIDTH_RSLT       = 16,
  parameter int FRACTIONAL_BITS_RSLT  = 12,
  parameter int SCALE_PER_FRAME       = 1,
  parameter int ROUND_ENABLE          = 1,
  parameter int ID_WIDTH              = 1,
  parameter int DEST_WIDTH            = 1,
  parameter int USER_WIDTH            = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  abs_mode,
  input  logic [LANES*DATA_WIDTH_DATA-1:0]      s_axis_data_tdata,
  input  logic                                  s_axis_data_tvalid,
  output logic                                  s_axis_data_tready,
  input  logic                                  s_axis_data_tlast,
  input  logic [ID_WIDTH-1:0]                   s_axis_data_tid,
  input  logic [DEST_WIDTH-1:0]                 s_axis_data_tdest,
  input  logic [USER_WIDTH-1:0]                 s_axis_data_tuser,
  input  logic [LANES*DATA_WIDTH_DATA-1:0]      s_axis_grid_tdata,
  input  logic                                  s_axis_grid_tvalid,
  output logic                                  s_axis_grid_tready,
  input  logic [LANES*DATA_WIDTH_SCALE-1:0]     s_axis_scale_tdata,
  input  logic                                  s_axis_scale_tvalid,
  output logic                                  s_axis_scale_tready,
  output logic [LANES*DATA_WIDTH_RSLT-1:0]      m_axis_tdata,
  output logic [LANES*DATA_WIDTH_RSLT/8-1:0]    m_axis_tkeep,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]                   m_axis_tid,
  output logic [DEST_WIDTH-1:0]                 m_axis_tdest,
  output logic [USER_WIDTH-1:0]                 m_axis_tuser,
  output logic [LANES-1:0]                      m_axis_sat,
  output logic                                  sat_sticky
);

  localparam int W     = DATA_WIDTH_DATA;
  localparam int SW    = DATA_WIDTH_SCALE;
  localparam int R     = DATA_WIDTH_RSLT;
  localparam int SH    = FRACTIONAL_BITS_DATA + FRACTIONAL_BITS_SCALE - FRACTIONAL_BITS_RSLT;
  localparam int SH_M1 = (SH > 0) ? SH - 1 : 0;
  localparam int PW    = W + 1 + SW;
  localparam int EW    = PW + 2;
  localparam int SBW   = 2 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  localparam logic signed [EW-1:0] ONE_E = EW'(1);
  localparam logic signed [EW-1:0] UMAX  = (ONE_E <<< R) - ONE_E;
  localparam logic signed [EW-1:0] SMAX  = (ONE_E <<< (R - 1)) - ONE_E;
  localparam logic signed [EW-1:0] SMIN  = -(ONE_E <<< (R - 1));
  localparam logic signed [EW-1:0] RND_C = (ROUND_ENABLE != 0 && SH > 0) ? (ONE_E <<< SH_M1) : '0;

  logic                     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [W:0]        diff_q [LANES];
  logic signed [W:0]        diff_d [LANES];
  logic signed [PW-1:0]     prod_q [LANES];
  logic signed [PW-1:0]     prod_d [LANES];
  logic [LANES*SW-1:0]      scale1_q, scale1_d;
  logic [LANES*SW-1:0]      scale_q, scale_d;
  logic                     scale_held_q, scale_held_d;
  logic [SBW-1:0]           sb1_q, sb1_d, sb2_q, sb2_d;
  logic [SBW-2:0]           sb3_q, sb3_d;
  logic [LANES*R-1:0]       rslt_q, rslt_d, rslt_c;
  logic [LANES-1:0]         sat_q, sat_d, sat_c;
  logic                     sat_sticky_q, sat_sticky_d;

  logic                     en, scale_avail, accept, scale_xfer;
  logic [LANES*SW-1:0]      cur_scale;
  logic signed [EW-1:0]     ext, shifted, mag;

  assign en          = !v3_q || m_axis_tready;
  assign scale_avail = (SCALE_PER_FRAME != 0) ? (scale_held_q || s_axis_scale_tvalid)
                                              : s_axis_scale_tvalid;
  // rst_n gating keeps every ready low while reset is held
  assign accept      = rst_n && en && s_axis_data_tvalid && s_axis_grid_tvalid && scale_avail;

  assign s_axis_data_tready  = accept;
  assign s_axis_grid_tready  = accept;
  assign s_axis_scale_tready = (SCALE_PER_FRAME != 0)
                               ? (rst_n && en && s_axis_data_tvalid && s_axis_grid_tvalid && !scale_held_q)
                               : accept;
  assign scale_xfer = s_axis_scale_tready && s_axis_scale_tvalid;
  assign cur_scale  = (SCALE_PER_FRAME != 0 && scale_held_q) ? scale_q : s_axis_scale_tdata;

  always_comb begin
    v1_d         = v1_q;
    v2_d         = v2_q;
    v3_d         = v3_q;
    diff_d       = diff_q;
    prod_d       = prod_q;
    scale1_d     = scale1_q;
    scale_d      = scale_q;
    scale_held_d = scale_held_q;
    sb1_d        = sb1_q;
    sb2_d        = sb2_q;
    sb3_d        = sb3_q;
    rslt_d       = rslt_q;
    sat_d        = sat_q;
    rslt_c       = '0;
    sat_c        = '0;
    ext          = '0;
    shifted      = '0;
    mag          = '0;

    if (SCALE_PER_FRAME != 0) begin
      if (scale_xfer) begin
        scale_d      = s_axis_scale_tdata;
        scale_held_d = 1'b1;
      end
      // frame end wins so a one-beat frame leaves nothing held
      if (accept && s_axis_data_tlast) scale_held_d = 1'b0;
    end

    for (int i = 0; i < LANES; i++) begin
      ext     = EW'(prod_q[i]) + RND_C;
      shifted = ext >>> SH;
      mag     = shifted[EW-1] ? -shifted : shifted;
      if (sb2_q[SBW-1]) begin
        if (mag > UMAX) begin
          rslt_c[i*R +: R] = UMAX[R-1:0];
          sat_c[i]         = v2_q;
        end else begin
          rslt_c[i*R +: R] = mag[R-1:0];
        end
      end else begin
        if (shifted > SMAX) begin
          rslt_c[i*R +: R] = SMAX[R-1:0];
          sat_c[i]         = v2_q;
        end else if (shifted < SMIN) begin
          rslt_c[i*R +: R] = SMIN[R-1:0];
          sat_c[i]         = v2_q;
        end else begin
          rslt_c[i*R +: R] = shifted[R-1:0];
        end
      end
    end

    if (en) begin
      v1_d = accept;
      v2_d = v1_q;
      v3_d = v2_q;
      for (int i = 0; i < LANES; i++) begin
        diff_d[i] = $signed({s_axis_data_tdata[i*W+W-1], s_axis_data_tdata[i*W +: W]})
                  - $signed({s_axis_grid_tdata[i*W+W-1], s_axis_grid_tdata[i*W +: W]});
        prod_d[i] = PW'(diff_q[i]) * PW'($signed(scale1_q[i*SW +: SW]));
      end
      scale1_d = cur_scale;
      sb1_d    = {abs_mode, s_axis_data_tlast, s_axis_data_tid, s_axis_data_tdest, s_axis_data_tuser};
      sb2_d    = sb1_q;
      sb3_d    = sb2_q[SBW-2:0];
      rslt_d   = rslt_c;
      sat_d    = sat_c;
    end

    sat_sticky_d = sat_sticky_q || (en && (|sat_c));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      v3_q         <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        diff_q[i] <= '0;
        prod_q[i] <= '0;
      end
      scale1_q     <= '0;
      scale_q      <= '0;
      scale_held_q <= 1'b0;
      sb1_q        <= '0;
      sb2_q        <= '0;
      sb3_q        <= '0;
      rslt_q       <= '0;
      sat_q        <= '0;
      sat_sticky_q <= 1'b0;
    end else begin
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      v3_q         <= v3_d;
      diff_q       <= diff_d;
      prod_q       <= prod_d;
      scale1_q     <= scale1_d;
      scale_q      <= scale_d;
      scale_held_q <= scale_held_d;
      sb1_q        <= sb1_d;
      sb2_q        <= sb2_d;
      sb3_q        <= sb3_d;
      rslt_q       <= rslt_d;
      sat_q        <= sat_d;
      sat_sticky_q <= sat_sticky_d;
    end
  end

  assign m_axis_tvalid = v3_q;
  assign m_axis_tdata  = rslt_q;
  assign m_axis_tkeep  = '1;
  assign m_axis_sat    = sat_q;
  assign sat_sticky    = sat_sticky_q;
  assign {m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} = sb3_q;

endmodule

// File: tb/tb_sub_mult_abs_vec.sv
// Directed bench for sub_mult_abs_vec: a per-frame/rounding instance and a
// per-beat/truncating instance share stimulus; outputs are scoreboarded.
module tb_sub_mult_abs_vec;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        abs_mode = 1'b0;
  logic [63:0] d_tdata = '0, g_tdata = '0, s_tdata = '0;
  logic        d_tvalid = 1'b0, d_tlast = 1'b0, g_tvalid = 1'b0, s_tvalid = 1'b0;
  logic [0:0]  d_tid = '0, d_tdest = '0, d_tuser = '0;
  logic        m_tready = 1'b1;

  logic        a_d_tready, a_g_tready, a_s_tready, a_tvalid, a_tlast, a_sticky;
  logic [63:0] a_tdata;
  logic [7:0]  a_tkeep;
  logic [0:0]  a_tid, a_tdest, a_tuser;
  logic [3:0]  a_sat;
  logic        b_d_tready, b_g_tready, b_s_tready, b_tvalid, b_tlast, b_sticky;
  logic [63:0] b_tdata;
  logic [7:0]  b_tkeep;
  logic [0:0]  b_tid, b_tdest, b_tuser;
  logic [3:0]  b_sat;

  sub_mult_abs_vec #(.SCALE_PER_FRAME(1), .ROUND_ENABLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .abs_mode(abs_mode),
    .s_axis_data_tdata(d_tdata), .s_axis_data_tvalid(d_tvalid), .s_axis_data_tready(a_d_tready),
    .s_axis_data_tlast(d_tlast), .s_axis_data_tid(d_tid), .s_axis_data_tdest(d_tdest),
    .s_axis_data_tuser(d_tuser),
    .s_axis_grid_tdata(g_tdata), .s_axis_grid_tvalid(g_tvalid), .s_axis_grid_tready(a_g_tready),
    .s_axis_scale_tdata(s_tdata), .s_axis_scale_tvalid(s_tvalid), .s_axis_scale_tready(a_s_tready),
    .m_axis_tdata(a_tdata), .m_axis_tkeep(a_tkeep), .m_axis_tvalid(a_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(a_tlast), .m_axis_tid(a_tid),
    .m_axis_tdest(a_tdest), .m_axis_tuser(a_tuser), .m_axis_sat(a_sat), .sat_sticky(a_sticky)
  );

  sub_mult_abs_vec #(.SCALE_PER_FRAME(0), .ROUND_ENABLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .abs_mode(abs_mode),
    .s_axis_data_tdata(d_tdata), .s_axis_data_tvalid(d_tvalid), .s_axis_data_tready(b_d_tready),
    .s_axis_data_tlast(d_tlast), .s_axis_data_tid(d_tid), .s_axis_data_tdest(d_tdest),
    .s_axis_data_tuser(d_tuser),
    .s_axis_grid_tdata(g_tdata), .s_axis_grid_tvalid(g_tvalid), .s_axis_grid_tready(b_g_tready),
    .s_axis_scale_tdata(s_tdata), .s_axis_scale_tvalid(s_tvalid), .s_axis_scale_tready(b_s_tready),
    .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep), .m_axis_tvalid(b_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(b_tlast), .m_axis_tid(b_tid),
    .m_axis_tdest(b_tdest), .m_axis_tuser(b_tuser), .m_axis_sat(b_sat), .sat_sticky(b_sticky)
  );

  typedef struct {
    logic [63:0] data;
    logic [3:0]  sat;
    logic        last;
    logic        id;
    logic        user;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ma, mb;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   spulse = 0;
  bit   held_m = 1'b0;
  bit   lat_en = 1'b0;
  logic [63:0] scale_m = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: round (optional) before magnitude, then clamp.
  function automatic logic [16:0] model_lane(input logic [15:0] x, input logic [15:0] g,
                                             input logic [15:0] s, input logic ab, input bit rnd);
    longint d, p, q, m;
    logic [15:0] r;
    logic st;
    d  = longint'($signed(x)) - longint'($signed(g));
    p  = d * longint'($signed(s));
    if (rnd) p = p + 2048;
    q  = p >>> 12;
    st = 1'b0;
    if (ab) begin
      m = (q < 0) ? -q : q;
      if (m > 65535) begin m = 65535; st = 1'b1; end
      r = m[15:0];
    end else begin
      if (q > 32767) begin q = 32767; st = 1'b1; end
      else if (q < -32768) begin q = -32768; st = 1'b1; end
      r = q[15:0];
    end
    return {st, r};
  endfunction

  function automatic void model_vec(input logic [63:0] x, input logic [63:0] g, input logic [63:0] s,
                                    input logic ab, input bit rnd,
                                    output logic [63:0] data, output logic [3:0] sat);
    logic [16:0] r;
    data = '0;
    sat  = '0;
    for (int i = 0; i < 4; i++) begin
      r = model_lane(x[i*16 +: 16], g[i*16 +: 16], s[i*16 +: 16], ab, rnd);
      data[i*16 +: 16] = r[15:0];
      sat[i]           = r[16];
    end
  endfunction

  function automatic logic [63:0] rep(input logic [15:0] v);
    return {4{v}};
  endfunction

  task automatic send(input logic [63:0] x, input logic [63:0] g, input logic [63:0] s,
                      input logic last, input logic ab, input logic id);
    exp_t ea, eb;
    bit got;
    d_tdata  = x;  g_tdata = g;  s_tdata = s;
    d_tlast  = last;  abs_mode = ab;
    d_tid    = id;  d_tdest = id;  d_tuser = id ^ last;
    d_tvalid = 1'b1;  g_tvalid = 1'b1;  s_tvalid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (a_d_tready) got = 1'b1;
    end
    chk("accept_timeout", {63'd0, got}, 64'd1);
    if (got) begin
      chk("scale_tready", {63'd0, a_s_tready}, {63'd0, !held_m});
      chk("grid_tready", {63'd0, a_g_tready}, 64'd1);
      chk("b_data_tready", {63'd0, b_d_tready}, 64'd1);
      if (a_s_tready) spulse++;
      if (!held_m) begin scale_m = s; held_m = 1'b1; end
      model_vec(x, g, scale_m, ab, 1'b1, ea.data, ea.sat);
      model_vec(x, g, s, ab, 1'b0, eb.data, eb.sat);
      if (last) held_m = 1'b0;
      ea.last = last;  ea.id = id;  ea.user = id ^ last;  ea.acc = cyc;  ea.lat = lat_en;
      eb.last = last;  eb.id = id;  eb.user = id ^ last;  eb.acc = cyc;  eb.lat = 1'b0;
      qa.push_back(ea);
      qb.push_back(eb);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    d_tvalid = 1'b0;  g_tvalid = 1'b0;  s_tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (qa.size() != 0 || qb.size() != 0); k++) @(negedge clk);
    chk("drain_a", 64'(qa.size()), 64'd0);
    chk("drain_b", 64'(qb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && a_tvalid && m_tready) begin
      if (qa.size() == 0) chk("a_unexpected", {63'd0, a_tvalid}, 64'd0);
      else begin
        ma = qa.pop_front();
        chk("a_data", a_tdata, ma.data);
        chk("a_sat", {60'd0, a_sat}, {60'd0, ma.sat});
        chk("a_last", {63'd0, a_tlast}, {63'd0, ma.last});
        chk("a_tid", {63'd0, a_tid}, {63'd0, ma.id});
        chk("a_tdest", {63'd0, a_tdest}, {63'd0, ma.id});
        chk("a_tuser", {63'd0, a_tuser}, {63'd0, ma.user});
        if (ma.lat) chk("a_latency", 64'(cyc - ma.acc), 64'd3);
      end
    end
    if (rst_n && b_tvalid && m_tready) begin
      if (qb.size() == 0) chk("b_unexpected", {63'd0, b_tvalid}, 64'd0);
      else begin
        mb = qb.pop_front();
        chk("b_data", b_tdata, mb.data);
        chk("b_sat", {60'd0, b_sat}, {60'd0, mb.sat});
        chk("b_last", {63'd0, b_tlast}, {63'd0, mb.last});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset: readies stay low even with valid inputs offered
    d_tvalid = 1'b1;  g_tvalid = 1'b1;  s_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", {63'd0, a_tvalid}, 64'd0);
    chk("rst_dready", {63'd0, a_d_tready}, 64'd0);
    chk("rst_gready", {63'd0, a_g_tready}, 64'd0);
    chk("rst_sready", {63'd0, a_s_tready}, 64'd0);
    chk("rst_sat", {60'd0, a_sat}, 64'd0);
    chk("rst_sticky", {63'd0, a_sticky}, 64'd0);
    idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic value and 3-cycle latency
    lat_en = 1'b1;
    send(rep(16'h2000), rep(16'h1000), rep(16'h2000), 1'b1, 1'b1, 1'b0);
    idle();
    lat_en = 1'b0;
    drain();
    chk("tkeep", {56'd0, a_tkeep}, 64'h00000000000000FF);

    // negative difference, abs and signed
    send(rep(16'h1000), rep(16'h3000), rep(16'h1000), 1'b1, 1'b1, 1'b1);
    send(rep(16'h1000), rep(16'h3000), rep(16'h1000), 1'b1, 1'b0, 1'b0);
    idle();
    drain();
    chk("sticky_clear", {63'd0, a_sticky}, 64'd0);

    // saturation in both modes plus a mixed-lane beat
    send(rep(16'h7000), rep(16'h8000), rep(16'h4000), 1'b1, 1'b1, 1'b0);
    send(rep(16'h7000), rep(16'h8000), rep(16'h4000), 1'b1, 1'b0, 1'b1);
    send({16'h7000, 16'h0001, 16'h1000, 16'h2000}, {16'h8000, 16'h0000, 16'h3000, 16'h1000},
         {16'h4000, 16'h0800, 16'h1000, 16'h2000}, 1'b1, 1'b0, 1'b0);
    idle();
    drain();
    chk("sticky_set_a", {63'd0, a_sticky}, 64'd1);
    chk("sticky_set_b", {63'd0, b_sticky}, 64'd1);

    // half-LSB: rounds up on A, truncates on B
    send(rep(16'h0001), rep(16'h0000), rep(16'h0800), 1'b1, 1'b1, 1'b1);
    idle();
    drain();

    // per-frame scale: 4-beat frame then 1-beat frame
    spulse = 0;
    for (int b = 0; b < 4; b++)
      send(rep(16'h0400 + 16'(b) * 16'h0100), rep(16'h0200),
           (b == 0) ? rep(16'h2000) : rep(16'h5555), (b == 3), 1'b1, b[0]);
    send(rep(16'h0900), rep(16'h0200), rep(16'h0C00), 1'b1, 1'b0, 1'b1);
    idle();
    drain();
    chk("scale_pulses", 64'(spulse), 64'd2);

    // backpressure: 6 beats offered with tready low for 5 cycles
    fork
      begin
        for (int b = 0; b < 6; b++)
          send({16'h0600 * 16'(b), 16'hF000 + 16'(b), 16'h1000, 16'h0300 * 16'(b)},
               rep(16'h0C00), rep(16'h1800), (b == 5), b[0], b[1]);
        idle();
      end
      begin
        m_tready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("stall_dready", {63'd0, a_d_tready}, 64'd0);
        chk("stall_tvalid", {63'd0, a_tvalid}, 64'd1);
        @(posedge clk); #1;
        m_tready = 1'b1;
      end
    join
    drain();

    // reset mid-frame drops in-flight beats and the held scale
    m_tready = 1'b0;
    send(rep(16'h1111), rep(16'h0100), rep(16'h3000), 1'b0, 1'b1, 1'b0);
    send(rep(16'h2222), rep(16'h0100), rep(16'h3000), 1'b0, 1'b1, 1'b1);
    d_tvalid = 1'b1;  g_tvalid = 1'b1;  s_tvalid = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_tvalid_a", {63'd0, a_tvalid}, 64'd0);
    chk("mid_rst_tvalid_b", {63'd0, b_tvalid}, 64'd0);
    chk("mid_rst_dready", {63'd0, a_d_tready}, 64'd0);
    chk("mid_rst_sready", {63'd0, a_s_tready}, 64'd0);
    chk("mid_rst_sticky", {63'd0, a_sticky}, 64'd0);
    chk("mid_rst_sat", {60'd0, a_sat}, 64'd0);
    qa.delete();
    qb.delete();
    held_m = 1'b0;
    idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_tready = 1'b1;
    @(posedge clk); #1;
    send(rep(16'h3000), rep(16'h1000), rep(16'h1800), 1'b0, 1'b1, 1'b1);
    send(rep(16'h0800), rep(16'h1000), rep(16'h7777), 1'b1, 1'b0, 1'b0);
    idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
